// File: rtl/cpu_pkg.sv
// Shared ROB types and sizing for the commit buffer and its retire selector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int PTR_W  = TAG_W + 1;
  localparam int P_W    = 5;
  localparam int R_W    = 3;
  localparam int N_AREG = 8;
  localparam int N_LANE = 3;

  // One ROB slot: status bits followed by the rename payload needed at commit.
  typedef struct packed {
    logic           valid;
    logic           done;
    logic           exp;
    logic           reg_wr;
    logic [R_W-1:0] rw;
    logic [P_W-1:0] pw;
    logic [P_W-1:0] pw_old;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Retire-enable chain over the three oldest ROB slots plus ARAT write merge.
// Latency: purely combinational from registered ROB state.
// Backpressure: none; block forces all lanes idle during a flush cycle.
module rob_retire_sel
  import cpu_pkg::*;
(
  input  logic              block,
  input  rob_entry_t        cand      [N_LANE],
  input  logic [P_W-1:0]    arat      [N_AREG],
  output logic [N_LANE-1:0] ret,
  output logic [N_LANE-1:0] reg_wr,
  output logic [N_LANE-1:0] exp,
  output logic [P_W-1:0]    pw_retire [N_LANE],
  output logic [P_W-1:0]    arat_next [N_AREG]
);

  logic chain;

  // A lane retires only when every older lane retires without an exception.
  always_comb begin
    chain = ~block;
    for (int k = 0; k < N_LANE; k++) begin
      ret[k]       = chain & cand[k].valid & cand[k].done;
      exp[k]       = ret[k] & cand[k].exp;
      reg_wr[k]    = ret[k] & ~cand[k].exp & cand[k].reg_wr;
      pw_retire[k] = (ret[k] & ~cand[k].exp) ? cand[k].pw_old : '0;
      chain        = ret[k] & ~cand[k].exp;
    end
  end

  // Apply committed mappings oldest first so the youngest write to an areg wins.
  always_comb begin
    arat_next = arat;
    for (int k = 0; k < N_LANE; k++) begin
      if (reg_wr[k]) begin
        arat_next[cand[k].rw] = cand[k].pw;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry, 3-wide in-order commit buffer with ARAT and exception flush.
// Latency: alloc tags combinational; completion visible to retire one cycle later; flush one cycle after the excepting retire.
// Backpressure: full_ROB (fewer than 3 free slots, from registered count) stalls allocation; allocs while full are dropped.
module reorder_buffer
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_issue_x,
  input  logic             valid_issue_y,
  input  logic             valid_issue_z,
  input  logic             RegWr_in_x,
  input  logic             RegWr_in_y,
  input  logic             RegWr_in_z,
  input  logic [R_W-1:0]   Rw_x,
  input  logic [R_W-1:0]   Rw_y,
  input  logic [R_W-1:0]   Rw_z,
  input  logic [P_W-1:0]   Pw_x,
  input  logic [P_W-1:0]   Pw_y,
  input  logic [P_W-1:0]   Pw_z,
  input  logic [P_W-1:0]   Pw_old_x,
  input  logic [P_W-1:0]   Pw_old_y,
  input  logic [P_W-1:0]   Pw_old_z,
  output logic [TAG_W-1:0] tag_ROB_x,
  output logic [TAG_W-1:0] tag_ROB_y,
  output logic [TAG_W-1:0] tag_ROB_z,
  output logic             full_ROB,
  input  logic             valid_Result_add,
  input  logic             valid_Result_mul,
  input  logic [TAG_W-1:0] tag_Result_add,
  input  logic [TAG_W-1:0] tag_Result_mul,
  input  logic             exp_Result_add,
  input  logic             exp_Result_mul,
  output logic             RegWr_x,
  output logic             RegWr_y,
  output logic             RegWr_z,
  output logic             exp_x,
  output logic             exp_y,
  output logic             exp_z,
  output logic [P_W-1:0]   Pw_retire_x,
  output logic [P_W-1:0]   Pw_retire_y,
  output logic [P_W-1:0]   Pw_retire_z,
  output logic             flush,
  output logic [P_W-1:0]   ARAT_P_list [N_AREG]
);

  rob_entry_t        entries [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  count;
  logic [TAG_W-1:0]  head_idx;
  logic [TAG_W-1:0]  tail_idx;

  logic [N_LANE-1:0] lane_vld;
  rob_entry_t        lane_ent [N_LANE];
  logic [TAG_W-1:0]  lane_tag [N_LANE];
  logic [PTR_W-1:0]  n_alloc;

  rob_entry_t        cand [N_LANE];
  logic [N_LANE-1:0] ret;
  logic [N_LANE-1:0] ret_wr;
  logic [N_LANE-1:0] ret_exp;
  logic [P_W-1:0]    ret_pw [N_LANE];
  logic [PTR_W-1:0]  n_ret;
  logic              except_ret;

  logic [P_W-1:0]    arat      [N_AREG];
  logic [P_W-1:0]    arat_next [N_AREG];

  // The wrap bit on the pointers distinguishes full from empty.
  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  assign count    = tail - head;
  assign full_ROB = (count > PTR_W'(DEPTH - N_LANE));

  // Gather lane requests and hand out compacted tags in lane order.
  always_comb begin
    lane_vld    = {valid_issue_z, valid_issue_y, valid_issue_x};
    lane_ent[0] = '{valid: 1'b1, done: 1'b0, exp: 1'b0, reg_wr: RegWr_in_x,
                    rw: Rw_x, pw: Pw_x, pw_old: Pw_old_x};
    lane_ent[1] = '{valid: 1'b1, done: 1'b0, exp: 1'b0, reg_wr: RegWr_in_y,
                    rw: Rw_y, pw: Pw_y, pw_old: Pw_old_y};
    lane_ent[2] = '{valid: 1'b1, done: 1'b0, exp: 1'b0, reg_wr: RegWr_in_z,
                    rw: Rw_z, pw: Pw_z, pw_old: Pw_old_z};
    lane_tag[0] = tail_idx;
    lane_tag[1] = lane_tag[0] + TAG_W'(lane_vld[0]);
    lane_tag[2] = lane_tag[1] + TAG_W'(lane_vld[1]);
    n_alloc     = PTR_W'(lane_vld[0]) + PTR_W'(lane_vld[1]) + PTR_W'(lane_vld[2]);
  end

  assign tag_ROB_x = lane_tag[0];
  assign tag_ROB_y = lane_tag[1];
  assign tag_ROB_z = lane_tag[2];

  // The three oldest slots, indexed mod DEPTH so retire wraps 15->0 seamlessly.
  always_comb begin
    for (int k = 0; k < N_LANE; k++) begin
      cand[k] = entries[head_idx + TAG_W'(k)];
    end
  end

  rob_retire_sel u_retire_sel (
    .block     (flush),
    .cand      (cand),
    .arat      (arat),
    .ret       (ret),
    .reg_wr    (ret_wr),
    .exp       (ret_exp),
    .pw_retire (ret_pw),
    .arat_next (arat_next)
  );

  assign n_ret      = PTR_W'(ret[0]) + PTR_W'(ret[1]) + PTR_W'(ret[2]);
  assign except_ret = |ret_exp;

  assign RegWr_x     = ret_wr[0];
  assign RegWr_y     = ret_wr[1];
  assign RegWr_z     = ret_wr[2];
  assign exp_x       = ret_exp[0];
  assign exp_y       = ret_exp[1];
  assign exp_z       = ret_exp[2];
  assign Pw_retire_x = ret_pw[0];
  assign Pw_retire_y = ret_pw[1];
  assign Pw_retire_z = ret_pw[2];

  // ROB state: completions, retire clears and allocations; an excepting retire squashes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (except_ret) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (!flush) begin
      if (valid_Result_add && entries[tag_Result_add].valid) begin
        entries[tag_Result_add].done <= 1'b1;
        entries[tag_Result_add].exp  <= exp_Result_add;
      end
      if (valid_Result_mul && entries[tag_Result_mul].valid) begin
        entries[tag_Result_mul].done <= 1'b1;
        entries[tag_Result_mul].exp  <= exp_Result_mul;
      end
      for (int k = 0; k < N_LANE; k++) begin
        if (ret[k]) begin
          entries[head_idx + TAG_W'(k)].valid <= 1'b0;
        end
      end
      if (!full_ROB) begin
        for (int k = 0; k < N_LANE; k++) begin
          if (lane_vld[k]) begin
            entries[lane_tag[k]] <= lane_ent[k];
          end
        end
        tail <= tail + n_alloc;
      end
      head <= head + n_ret;
    end
  end

  // Committed map; the selector already holds it unchanged during flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_AREG; i++) begin
        arat[i] <= P_W'(i);
      end
    end else begin
      arat <= arat_next;
    end
  end

  assign ARAT_P_list = arat;

  // One-cycle flush pulse following the edge that retires an excepting entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush <= 1'b0;
    end else begin
      flush <= except_ret;
    end
  end

  // The front end must honour full_ROB; anything sent anyway is silently dropped.
  a_no_alloc_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(full_ROB && !flush && (|lane_vld)));

  // ADD and MUL pipes can never finish the same instruction.
  a_distinct_completion: assert property (@(posedge clk) disable iff (!rst)
    !(valid_Result_add && valid_Result_mul && (tag_Result_add == tag_Result_mul)));

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: tag vector table, retire scoreboard, exception and reset sequences.
// Latency: checks combinational tags before the edge and registered state after it.
// Backpressure: stimulus only allocates when the model count leaves room for three lanes.
module tb_reorder_buffer;
  import cpu_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_issue_x, valid_issue_y, valid_issue_z;
  logic             RegWr_in_x, RegWr_in_y, RegWr_in_z;
  logic [R_W-1:0]   Rw_x, Rw_y, Rw_z;
  logic [P_W-1:0]   Pw_x, Pw_y, Pw_z;
  logic [P_W-1:0]   Pw_old_x, Pw_old_y, Pw_old_z;
  logic [TAG_W-1:0] tag_ROB_x, tag_ROB_y, tag_ROB_z;
  logic             full_ROB;
  logic             valid_Result_add, valid_Result_mul;
  logic [TAG_W-1:0] tag_Result_add, tag_Result_mul;
  logic             exp_Result_add, exp_Result_mul;
  logic             RegWr_x, RegWr_y, RegWr_z;
  logic             exp_x, exp_y, exp_z;
  logic [P_W-1:0]   Pw_retire_x, Pw_retire_y, Pw_retire_z;
  logic             flush;
  logic [P_W-1:0]   ARAT_P_list [N_AREG];

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .valid_issue_x(valid_issue_x), .valid_issue_y(valid_issue_y), .valid_issue_z(valid_issue_z),
    .RegWr_in_x(RegWr_in_x), .RegWr_in_y(RegWr_in_y), .RegWr_in_z(RegWr_in_z),
    .Rw_x(Rw_x), .Rw_y(Rw_y), .Rw_z(Rw_z),
    .Pw_x(Pw_x), .Pw_y(Pw_y), .Pw_z(Pw_z),
    .Pw_old_x(Pw_old_x), .Pw_old_y(Pw_old_y), .Pw_old_z(Pw_old_z),
    .tag_ROB_x(tag_ROB_x), .tag_ROB_y(tag_ROB_y), .tag_ROB_z(tag_ROB_z),
    .full_ROB(full_ROB),
    .valid_Result_add(valid_Result_add), .valid_Result_mul(valid_Result_mul),
    .tag_Result_add(tag_Result_add), .tag_Result_mul(tag_Result_mul),
    .exp_Result_add(exp_Result_add), .exp_Result_mul(exp_Result_mul),
    .RegWr_x(RegWr_x), .RegWr_y(RegWr_y), .RegWr_z(RegWr_z),
    .exp_x(exp_x), .exp_y(exp_y), .exp_z(exp_z),
    .Pw_retire_x(Pw_retire_x), .Pw_retire_y(Pw_retire_y), .Pw_retire_z(Pw_retire_z),
    .flush(flush),
    .ARAT_P_list(ARAT_P_list)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [R_W-1:0]   rw;
    logic [P_W-1:0]   pw;
    logic [P_W-1:0]   pw_old;
    logic             exc;
  } rec_t;

  typedef struct {
    logic [R_W-1:0] rw;
    logic [P_W-1:0] pw;
    logic [P_W-1:0] pw_old;
  } lane_t;

  typedef struct {
    logic [2:0]       v;
    logic [TAG_W-1:0] tx;
    logic [TAG_W-1:0] ty;
    logic [TAG_W-1:0] tz;
    logic             full;
  } vec_t;

  rec_t             sb_q [$];
  logic [TAG_W-1:0] pend [$];
  logic [TAG_W-1:0] model_tail;
  logic [P_W-1:0]   model_arat [N_AREG];
  int               n_checks = 0;
  int               n_fail = 0;
  int               seq = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_idle();
    valid_issue_x = 0; valid_issue_y = 0; valid_issue_z = 0;
    RegWr_in_x = 0; RegWr_in_y = 0; RegWr_in_z = 0;
    Rw_x = '0; Rw_y = '0; Rw_z = '0;
    Pw_x = '0; Pw_y = '0; Pw_z = '0;
    Pw_old_x = '0; Pw_old_y = '0; Pw_old_z = '0;
    valid_Result_add = 0; valid_Result_mul = 0;
    tag_Result_add = '0; tag_Result_mul = '0;
    exp_Result_add = 0; exp_Result_mul = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic reset_models();
    sb_q.delete();
    pend.delete();
    model_tail = '0;
    for (int i = 0; i < N_AREG; i++) model_arat[i] = P_W'(i);
  endtask

  function automatic lane_t mk_lane();
    lane_t l;
    seq++;
    l.rw     = R_W'($urandom_range(0, N_AREG - 1));
    l.pw     = P_W'($urandom_range(0, 31));
    l.pw_old = P_W'(seq);
    return l;
  endfunction

  task automatic drive_alloc(input logic [2:0] m, input lane_t l0, input lane_t l1, input lane_t l2);
    lane_t l [3];
    l = '{l0, l1, l2};
    valid_issue_x = m[0]; RegWr_in_x = 1; Rw_x = l0.rw; Pw_x = l0.pw; Pw_old_x = l0.pw_old;
    valid_issue_y = m[1]; RegWr_in_y = 1; Rw_y = l1.rw; Pw_y = l1.pw; Pw_old_y = l1.pw_old;
    valid_issue_z = m[2]; RegWr_in_z = 1; Rw_z = l2.rw; Pw_z = l2.pw; Pw_old_z = l2.pw_old;
    for (int k = 0; k < 3; k++) begin
      if (m[k]) begin
        sb_q.push_back('{tag: model_tail, rw: l[k].rw, pw: l[k].pw, pw_old: l[k].pw_old, exc: 1'b0});
        pend.push_back(model_tail);
        model_tail = model_tail + 1'b1;
      end
    end
  endtask

  task automatic complete_tag(input bit on_mul, input logic [TAG_W-1:0] t, input logic e);
    if (on_mul) begin
      valid_Result_mul = 1; tag_Result_mul = t; exp_Result_mul = e;
    end else begin
      valid_Result_add = 1; tag_Result_add = t; exp_Result_add = e;
    end
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i] == t) begin
        pend.delete(i);
        break;
      end
    end
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].tag == t) sb_q[i].exc = e;
    end
  endtask

  task automatic complete_random(input int n);
    for (int j = 0; j < n; j++) begin
      if (pend.size() > 0) begin
        int idx;
        idx = $urandom_range(0, pend.size() - 1);
        complete_tag(j == 1, pend[idx], 1'b0);
      end
    end
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 400) begin
      complete_random(2);
      step();
      cyc++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  // Retire monitor: each visible retiring lane must match the oldest outstanding allocation.
  always @(negedge clk) begin
    logic [2:0]     rv;
    logic [2:0]     ev;
    logic [P_W-1:0] pr [3];
    rec_t           rec;
    rv = {RegWr_z, RegWr_y, RegWr_x};
    ev = {exp_z, exp_y, exp_x};
    pr = '{Pw_retire_x, Pw_retire_y, Pw_retire_z};
    if (rst === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        if (rv[k] || ev[k]) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL retire_unexpected: lane %0d retired with nothing outstanding (t=%0t)", k, $time);
          end else begin
            rec = sb_q.pop_front();
            chk("retire_exp_flag", ev[k], rec.exc);
            if (!ev[k]) begin
              chk("retire_pw_old", pr[k], rec.pw_old);
              model_arat[rec.rw] = rec.pw;
            end else begin
              sb_q.delete();
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    vec_t       tbl [9];
    logic [TAG_W-1:0] t0;
    int         allocd;
    int         cyc;
    logic [2:0] m;

    // Alloc patterns from an empty ROB with no completions: expected tags and full flag per row.
    tbl[0] = '{v: 3'b101, tx: 4'd0,  ty: 4'd1,  tz: 4'd1,  full: 1'b0};
    tbl[1] = '{v: 3'b001, tx: 4'd2,  ty: 4'd3,  tz: 4'd3,  full: 1'b0};
    tbl[2] = '{v: 3'b110, tx: 4'd3,  ty: 4'd3,  tz: 4'd4,  full: 1'b0};
    tbl[3] = '{v: 3'b111, tx: 4'd5,  ty: 4'd6,  tz: 4'd7,  full: 1'b0};
    tbl[4] = '{v: 3'b000, tx: 4'd8,  ty: 4'd8,  tz: 4'd8,  full: 1'b0};
    tbl[5] = '{v: 3'b011, tx: 4'd8,  ty: 4'd9,  tz: 4'd10, full: 1'b0};
    tbl[6] = '{v: 3'b100, tx: 4'd10, ty: 4'd10, tz: 4'd10, full: 1'b0};
    tbl[7] = '{v: 3'b111, tx: 4'd11, ty: 4'd12, tz: 4'd13, full: 1'b0};
    tbl[8] = '{v: 3'b000, tx: 4'd14, ty: 4'd14, tz: 4'd14, full: 1'b1};

    rst = 1'b0;
    set_idle();
    reset_models();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state.
    for (int i = 0; i < N_AREG; i++) chk("reset_arat", ARAT_P_list[i], i);
    chk("reset_full", full_ROB, 0);
    chk("reset_flush", flush, 0);
    chk("reset_regwr_x", RegWr_x, 0);
    chk("reset_exp_x", exp_x, 0);
    valid_issue_x = 1; valid_issue_y = 1; valid_issue_z = 1;
    #1;
    chk("reset_tag_x", tag_ROB_x, 0);
    chk("reset_tag_y", tag_ROB_y, 1);
    chk("reset_tag_z", tag_ROB_z, 2);
    set_idle();

    // Tag compaction and fill-to-full from the vector table.
    for (int i = 0; i < 9; i++) begin
      drive_alloc(tbl[i].v, mk_lane(), mk_lane(), mk_lane());
      #1;
      chk("vec_tag_x", tag_ROB_x, tbl[i].tx);
      chk("vec_tag_y", tag_ROB_y, tbl[i].ty);
      chk("vec_tag_z", tag_ROB_z, tbl[i].tz);
      chk("vec_full", full_ROB, tbl[i].full);
      step();
    end

    // Younger completion first: head must hold until tag 0 is done, then both retire together.
    complete_tag(1'b0, 4'd1, 1'b0);
    step();
    chk("ooo_hold_regwr_x", RegWr_x, 0);
    complete_tag(1'b0, 4'd0, 1'b0);
    step();
    chk("ooo_pair_regwr_x", RegWr_x, 1);
    chk("ooo_pair_regwr_y", RegWr_y, 1);
    chk("ooo_pair_regwr_z", RegWr_z, 0);
    chk("ooo_pair_full_before", full_ROB, 1);
    step();
    chk("ooo_full_released", full_ROB, 0);
    drain("drain_after_fill");

    // Randomised stream of at least 40 instructions, crossing the index wrap several times.
    allocd = 0;
    cyc = 0;
    while (allocd < 40 && cyc < 2000) begin
      chk("stream_full", full_ROB, (sb_q.size() > DEPTH - N_LANE));
      complete_random($urandom_range(0, 2));
      if (sb_q.size() <= DEPTH - N_LANE) begin
        t0 = model_tail;
        m = 3'($urandom_range(1, 7));
        drive_alloc(m, mk_lane(), mk_lane(), mk_lane());
        allocd += $countones(m);
        #1;
        chk("stream_tag_x", tag_ROB_x, t0);
      end
      step();
      cyc++;
    end
    chk("stream_budget", (cyc < 2000), 1);
    drain("drain_after_stream");

    // Three-lane retire in one cycle with youngest-wins ARAT update.
    t0 = model_tail;
    drive_alloc(3'b111, '{rw: 3'd1, pw: 5'd8, pw_old: 5'd1},
                        '{rw: 3'd1, pw: 5'd9, pw_old: 5'd8},
                        '{rw: 3'd2, pw: 5'd10, pw_old: 5'd2});
    step();
    complete_tag(1'b0, t0 + 4'd1, 1'b0);
    complete_tag(1'b1, t0 + 4'd2, 1'b0);
    step();
    complete_tag(1'b0, t0, 1'b0);
    step();
    chk("tri_regwr_x", RegWr_x, 1);
    chk("tri_regwr_y", RegWr_y, 1);
    chk("tri_regwr_z", RegWr_z, 1);
    chk("tri_pw_retire_x", Pw_retire_x, 1);
    chk("tri_pw_retire_y", Pw_retire_y, 8);
    chk("tri_pw_retire_z", Pw_retire_z, 2);
    step();
    chk("tri_arat_1", ARAT_P_list[1], 9);
    chk("tri_arat_2", ARAT_P_list[2], 10);
    chk("tri_empty", sb_q.size(), 0);

    // Exception on the middle entry: older commits, excepting one frees nothing, younger squashed.
    t0 = model_tail;
    drive_alloc(3'b111, '{rw: 3'd3, pw: 5'd20, pw_old: 5'd11},
                        '{rw: 3'd4, pw: 5'd21, pw_old: 5'd12},
                        '{rw: 3'd5, pw: 5'd22, pw_old: 5'd13});
    step();
    complete_tag(1'b0, t0 + 4'd1, 1'b1);
    complete_tag(1'b1, t0 + 4'd2, 1'b0);
    step();
    complete_tag(1'b0, t0, 1'b0);
    step();
    chk("exc_regwr_x", RegWr_x, 1);
    chk("exc_pw_retire_x", Pw_retire_x, 11);
    chk("exc_exp_x", exp_x, 0);
    chk("exc_exp_y", exp_y, 1);
    chk("exc_regwr_y", RegWr_y, 0);
    chk("exc_regwr_z", RegWr_z, 0);
    chk("exc_exp_z", exp_z, 0);
    chk("exc_flush_not_yet", flush, 0);
    step();
    chk("exc_flush_pulse", flush, 1);
    chk("exc_full_during_flush", full_ROB, 0);
    chk("exc_regwr_x_flush", RegWr_x, 0);
    chk("exc_exp_y_flush", exp_y, 0);
    chk("exc_arat_3", ARAT_P_list[3], 20);
    for (int i = 0; i < N_AREG; i++) chk("exc_arat_model", ARAT_P_list[i], model_arat[i]);
    valid_issue_x = 1; RegWr_in_x = 1; Rw_x = 3'd6; Pw_x = 5'd30; Pw_old_x = 5'd6;
    #1;
    chk("exc_tag_x_flush", tag_ROB_x, 0);
    step();
    chk("exc_flush_done", flush, 0);
    chk("exc_tag_x_after", tag_ROB_x, 0);
    chk("exc_full_after", full_ROB, 0);
    pend.delete();
    model_tail = '0;

    // Asynchronous reset in the middle of a burst.
    drive_alloc(3'b111, mk_lane(), mk_lane(), mk_lane());
    step();
    drive_alloc(3'b111, mk_lane(), mk_lane(), mk_lane());
    complete_random(2);
    step();
    complete_random(2);
    drive_alloc(3'b011, mk_lane(), mk_lane(), mk_lane());
    #2 rst = 1'b0;
    #1;
    chk("arst_full", full_ROB, 0);
    chk("arst_flush", flush, 0);
    chk("arst_regwr_x", RegWr_x, 0);
    chk("arst_exp_x", exp_x, 0);
    chk("arst_pw_retire_x", Pw_retire_x, 0);
    chk("arst_tag_x", tag_ROB_x, 0);
    for (int i = 0; i < N_AREG; i++) chk("arst_arat", ARAT_P_list[i], i);
    reset_models();
    set_idle();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("post_arst_flush", flush, 0);
      chk("post_arst_regwr_x", RegWr_x, 0);
      chk("post_arst_full", full_ROB, 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
